// File: rtl/pim_req_arbiter.sv
// Round-robin front end that merges NUM_PORTS requesters onto one in-order DDR3 channel.
// Optional macro PIM_ARB_PRIO0_EN gives port 0 strict priority over the round-robin ports.
module pim_req_arbiter #(
    parameter int NUM_PORTS = 4,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 512,
    parameter int MAX_OUTST = 4,
    parameter int CNT_W     = 32,
    localparam int PW       = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1,
    localparam int AW       = $clog2(MAX_OUTST),
    localparam int OW       = AW + 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_PORTS-1:0]        up_req_valid,
    output logic [NUM_PORTS-1:0]        up_req_ready,
    input  logic [NUM_PORTS*ADDR_W-1:0] up_req_addr,
    output logic [NUM_PORTS-1:0]        up_resp_valid,
    input  logic [NUM_PORTS-1:0]        up_resp_ready,
    output logic [DATA_W-1:0]           up_resp_data,
    output logic                        dn_req_valid,
    input  logic                        dn_req_ready,
    output logic [ADDR_W-1:0]           dn_req_addr,
    input  logic                        dn_resp_valid,
    output logic                        dn_resp_ready,
    input  logic [DATA_W-1:0]           dn_resp_data,
    output logic [NUM_PORTS*CNT_W-1:0]  grant_count,
    output logic [CNT_W-1:0]            stall_count,
    output logic [OW-1:0]               outstanding,
    output logic                        spurious_resp
);

    localparam logic [OW-1:0] FULL_CNT = OW'(MAX_OUTST);

    logic [PW-1:0]    rr_ptr;
    logic [PW-1:0]    grant;
    logic [PW-1:0]    next_rr;
    logic [PW-1:0]    head;
    logic [PW-1:0]    tag_mem [MAX_OUTST];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [OW-1:0]    count;
    logic [CNT_W-1:0] gcnt [NUM_PORTS];
    logic             full;
    logic             empty;
    logic             any_req;
    logic             push;
    logic             pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign any_req = |up_req_valid;
    assign head    = tag_mem[rd_ptr];

    // First requester at or after rr_ptr, wrapping; port 0 may pre-empt the scan.
    always_comb begin
        logic found;
        int   idx;
        grant = '0;
        found = 1'b0;
        idx   = 0;
`ifdef PIM_ARB_PRIO0_EN
        if (up_req_valid[0]) begin
            found = 1'b1;
        end
`endif
        for (int k = 0; k < NUM_PORTS; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
            if (!found && up_req_valid[idx]) begin
                grant = PW'(idx);
                found = 1'b1;
            end
        end
    end

    assign next_rr = (int'(grant) == NUM_PORTS - 1) ? '0 : grant + 1'b1;

    always_comb begin
        dn_req_valid  = any_req & ~full;
        dn_req_addr   = up_req_addr[grant*ADDR_W +: ADDR_W];
        up_req_ready  = '0;
        if (dn_req_valid && dn_req_ready) up_req_ready[grant] = 1'b1;

        up_resp_data  = dn_resp_data;
        up_resp_valid = '0;
        if (dn_resp_valid && !empty) up_resp_valid[head] = 1'b1;
        dn_resp_ready = ~empty & up_resp_ready[head];
    end

    assign push        = dn_req_valid & dn_req_ready;
    assign pop         = dn_resp_valid & dn_resp_ready;
    assign outstanding = count;

    always_comb begin
        grant_count = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            grant_count[i*CNT_W +: CNT_W] = gcnt[i];
        end
    end

    // Tag storage carries no reset; occupancy and pointers alone define validity.
    always_ff @(posedge clk) begin
        if (push) tag_mem[wr_ptr] <= grant;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr        <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            stall_count   <= '0;
            spurious_resp <= 1'b0;
            for (int i = 0; i < NUM_PORTS; i++) gcnt[i] <= '0;
        end else begin
            if (push) begin
                wr_ptr      <= wr_ptr + 1'b1;
                gcnt[grant] <= gcnt[grant] + 1'b1;
`ifdef PIM_ARB_PRIO0_EN
                if (grant != '0) rr_ptr <= next_rr;
`else
                rr_ptr <= next_rr;
`endif
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (any_req && full) stall_count <= stall_count + 1'b1;
            if (dn_resp_valid && empty) spurious_resp <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pim_req_arbiter.sv
// Bench for pim_req_arbiter: queue-based reference model checked every cycle, plus directed scenarios.
module tb_pim_req_arbiter;
    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 512;
    localparam int MO = 4;
    localparam int CW = 32;
    localparam int OW = $clog2(MO) + 1;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    up_req_valid, up_req_ready, up_resp_valid, up_resp_ready;
    logic [N*AW-1:0] up_req_addr;
    logic [DW-1:0]   up_resp_data, dn_resp_data;
    logic            dn_req_valid, dn_req_ready, dn_resp_valid, dn_resp_ready;
    logic [AW-1:0]   dn_req_addr;
    logic [N*CW-1:0] grant_count;
    logic [CW-1:0]   stall_count;
    logic [OW-1:0]   outstanding;
    logic            spurious_resp;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int          rr;
    int          mq[$];
    int          mg[N];
    int          mstall;
    bit          mspur;
    int          glog[$];

    pim_req_arbiter #(.NUM_PORTS(N), .ADDR_W(AW), .DATA_W(DW), .MAX_OUTST(MO), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .up_req_valid(up_req_valid), .up_req_ready(up_req_ready), .up_req_addr(up_req_addr),
        .up_resp_valid(up_resp_valid), .up_resp_ready(up_resp_ready), .up_resp_data(up_resp_data),
        .dn_req_valid(dn_req_valid), .dn_req_ready(dn_req_ready), .dn_req_addr(dn_req_addr),
        .dn_resp_valid(dn_resp_valid), .dn_resp_ready(dn_resp_ready), .dn_resp_data(dn_resp_data),
        .grant_count(grant_count), .stall_count(stall_count), .outstanding(outstanding),
        .spurious_resp(spurious_resp)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic int model_grant();
`ifdef PIM_ARB_PRIO0_EN
        if (up_req_valid[0]) return 0;
`endif
        for (int k = 0; k < N; k++) begin
            if (up_req_valid[(rr + k) % N]) return (rr + k) % N;
        end
        return 0;
    endfunction

    // Per-cycle comparison against the model, then advance the model to the next edge.
    always @(negedge clk) begin
        bit           full, empty, anyv, exp_dv, exp_drr;
        int           g, head;
        logic [N-1:0] exp_rdy, exp_rv;
        if (!rst_n) begin
            rr = 0; mq.delete(); mstall = 0; mspur = 0;
            for (int i = 0; i < N; i++) mg[i] = 0;
        end
        full    = (mq.size() == MO);
        empty   = (mq.size() == 0);
        anyv    = |up_req_valid;
        g       = model_grant();
        head    = empty ? 0 : mq[0];
        exp_dv  = anyv && !full;
        exp_rdy = '0;
        if (exp_dv && dn_req_ready) exp_rdy[g] = 1'b1;
        exp_rv  = '0;
        if (dn_resp_valid && !empty) exp_rv[head] = 1'b1;
        exp_drr = !empty && up_resp_ready[head];

        check("dn_req_valid", DW'(dn_req_valid), DW'(exp_dv));
        check("up_req_ready", DW'(up_req_ready), DW'(exp_rdy));
        if (anyv) check("dn_req_addr", DW'(dn_req_addr), DW'(up_req_addr[g*AW +: AW]));
        check("up_resp_valid", DW'(up_resp_valid), DW'(exp_rv));
        check("dn_resp_ready", DW'(dn_resp_ready), DW'(exp_drr));
        check("up_resp_data", up_resp_data, dn_resp_data);
        check("outstanding", DW'(outstanding), DW'(mq.size()));
        check("stall_count", DW'(stall_count), DW'(CW'(mstall)));
        check("spurious_resp", DW'(spurious_resp), DW'(mspur));
        for (int i = 0; i < N; i++) check("grant_count", DW'(grant_count[i*CW +: CW]), DW'(CW'(mg[i])));

        if (rst_n && dn_req_valid && dn_req_ready) begin
            for (int i = 0; i < N; i++) if (up_req_ready[i]) glog.push_back(i);
        end

        if (rst_n) begin
            if (dn_resp_valid && exp_drr) void'(mq.pop_front());
            if (exp_dv && dn_req_ready) begin
                mq.push_back(g);
                mg[g]++;
`ifdef PIM_ARB_PRIO0_EN
                if (g != 0) rr = (g + 1) % N;
`else
                rr = (g + 1) % N;
`endif
            end
            if (anyv && full) mstall++;
            if (dn_resp_valid && empty) mspur = 1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_addr_data();
        for (int i = 0; i < N; i++) up_req_addr[i*AW +: AW] = $urandom;
        for (int w = 0; w < DW / 32; w++) dn_resp_data[w*32 +: 32] = $urandom;
    endtask

    task automatic drain();
        up_req_valid = '0;
        for (int t = 0; t < 20 && mq.size() > 0; t++) begin
            dn_resp_valid = 1'b1;
            up_resp_ready = '1;
            rand_addr_data();
            step();
        end
        dn_resp_valid = 1'b0;
        #1;
        check("drain_outstanding", DW'(outstanding), DW'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

    initial begin
        int exp_ord[8];
        int exp_cnt[N];

        rst_n = 1'b0; up_req_valid = '0; up_req_addr = '0; up_resp_ready = '0;
        dn_req_ready = 1'b1; dn_resp_valid = 1'b0; dn_resp_data = '0;
        step(); step();
        #1;
        check("rst_dn_req_valid", DW'(dn_req_valid), DW'(0));
        check("rst_up_req_ready", DW'(up_req_ready), DW'(0));
        check("rst_up_resp_valid", DW'(up_resp_valid), DW'(0));
        check("rst_dn_resp_ready", DW'(dn_resp_ready), DW'(0));
        check("rst_outstanding", DW'(outstanding), DW'(0));
        rst_n = 1'b1;
        step();

        // All four ports requesting continuously, one response in flight per cycle.
        glog.delete();
        up_req_valid = 4'hF; up_resp_ready = 4'hF;
        for (int i = 0; i < 8; i++) begin
            rand_addr_data();
            dn_resp_valid = (mq.size() > 0);
            step();
        end
        drain();
`ifdef PIM_ARB_PRIO0_EN
        exp_ord = '{0, 0, 0, 0, 0, 0, 0, 0};
`else
        exp_ord = '{0, 1, 2, 3, 0, 1, 2, 3};
`endif
        for (int i = 0; i < N; i++) exp_cnt[i] = 0;
        for (int i = 0; i < 8; i++) exp_cnt[exp_ord[i]]++;
        check("grant_log_len", DW'(glog.size()), DW'(8));
        for (int i = 0; i < 8 && i < glog.size(); i++) check("grant_order", DW'(glog[i]), DW'(exp_ord[i]));
        for (int i = 0; i < N; i++) check("grant_count_lit", DW'(grant_count[i*CW +: CW]), DW'(exp_cnt[i]));

        // Port 2 alone fills the tag FIFO; a pop does not free a slot in the same cycle.
        up_req_valid = 4'b0100;
        repeat (4) step();
        #1;
        check("full_outstanding", DW'(outstanding), DW'(4));
        check("full_up_req_ready", DW'(up_req_ready), DW'(0));
        check("full_dn_req_valid", DW'(dn_req_valid), DW'(0));
        step(); step();
        #1;
        check("stall_count_lit", DW'(stall_count), DW'(2));
        dn_resp_valid = 1'b1;
        #1;
        check("no_bypass_ready", DW'(up_req_ready), DW'(0));
        check("full_pop_ready", DW'(dn_resp_ready), DW'(1));
        step();
        dn_resp_valid = 1'b0;
        #1;
        check("after_pop_outstanding", DW'(outstanding), DW'(3));
        check("after_pop_ready", DW'(up_req_ready), DW'(4'b0100));
        step();
        #1;
        check("refill_outstanding", DW'(outstanding), DW'(4));
        drain();

        // Tags [1,3]; port 1 backpressures its response.
        up_req_valid = 4'b0010; step();
        up_req_valid = 4'b1000; step();
        up_req_valid = 4'b0000;
        dn_resp_valid = 1'b1; up_resp_ready = 4'b1101;
        #1;
        check("hold_dn_resp_ready", DW'(dn_resp_ready), DW'(0));
        check("hold_up_resp_valid", DW'(up_resp_valid), DW'(4'b0010));
        step();
        #1;
        check("hold_outstanding", DW'(outstanding), DW'(2));
        up_resp_ready = 4'hF;
        #1;
        check("release_dn_resp_ready", DW'(dn_resp_ready), DW'(1));
        step();
        #1;
        check("head3_up_resp_valid", DW'(up_resp_valid), DW'(4'b1000));
        check("head3_outstanding", DW'(outstanding), DW'(1));
        step();
        dn_resp_valid = 1'b0;
        #1;
        check("tags_drained", DW'(outstanding), DW'(0));

        // Response with nothing outstanding.
        check("spur_clear", DW'(spurious_resp), DW'(0));
        dn_resp_valid = 1'b1;
        #1;
        check("spur_dn_resp_ready", DW'(dn_resp_ready), DW'(0));
        step();
        dn_resp_valid = 1'b0;
        #1;
        check("spur_set", DW'(spurious_resp), DW'(1));
        step(); step();
        check("spur_sticky", DW'(spurious_resp), DW'(1));

`ifdef PIM_ARB_PRIO0_EN
        glog.delete();
        up_req_valid = 4'b0011;
        repeat (3) step();
        up_req_valid = 4'b0010;
        step();
        drain();
        check("prio_log_len", DW'(glog.size()), DW'(4));
        if (glog.size() == 4) begin
            check("prio_g0", DW'(glog[0]), DW'(0));
            check("prio_g1", DW'(glog[1]), DW'(0));
            check("prio_g2", DW'(glog[2]), DW'(0));
            check("prio_g3", DW'(glog[3]), DW'(1));
        end
`endif

        // Randomized traffic with a reset in the middle.
        for (int c = 0; c < 600; c++) begin
            up_req_valid  = N'($urandom);
            dn_req_ready  = ($urandom % 4) != 0;
            up_resp_ready = N'($urandom | $urandom);
            dn_resp_valid = (mq.size() > 0) ? (($urandom % 4) != 0) : (($urandom % 64) == 0);
            rand_addr_data();
            if (c == 300) begin
                rst_n = 1'b0;
                #1;
                check("mid_rst_outstanding", DW'(outstanding), DW'(0));
                check("mid_rst_spurious", DW'(spurious_resp), DW'(0));
                check("mid_rst_stall", DW'(stall_count), DW'(0));
                check("mid_rst_grant_count", DW'(grant_count), DW'(0));
            end
            step();
            if (c == 300) rst_n = 1'b1;
        end
        drain();

        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
